// File: rtl/rr_timeout_arb_pkg.sv
// Shared types and constants for the round-robin timeout arbiter.
// Latency: none (declarations only); backpressure: n/a.
package rr_timeout_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_EXPIRE = 2'd2
  } arb_state_e;

  localparam int DFLT_TIMEOUT = 40;

endpackage

// File: rtl/counter2.sv
// Wrap-around counter cell: loadable, counts on add, flags the last value before wrap.
// Latency: count updates one cycle after add/set; end_o is combinational; backpressure: n/a.
module counter2 #(
  parameter int CNT_SIZE       = 40,
  parameter int CNT_SIZE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_i,
  input  logic [CNT_SIZE_WIDTH-1:0] set_val_i,
  input  logic                      add_i,
  output logic [CNT_SIZE_WIDTH-1:0] cnt_o,
  output logic                      end_o
);

  localparam logic [CNT_SIZE_WIDTH-1:0] CNT_LAST = CNT_SIZE_WIDTH'(CNT_SIZE - 1);

  logic [CNT_SIZE_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (set_i) begin
      cnt_q <= set_val_i;
    end else if (add_i) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign end_o = add_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rr_timeout_arb.sv
// Round-robin arbiter with a per-grant watchdog that revokes ownership after TIMEOUT cycles.
// Latency: request to grant 1 cycle; no backpressure, en_i only gates new grants.
module rr_timeout_arb
  import rr_timeout_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2,
  parameter int TIMEOUT   = DFLT_TIMEOUT,
  parameter int TIMEOUT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 release_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [REQ_IDX_W-1:0] gnt_idx_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [TIMEOUT_W-1:0] hold_cnt_o
);

  localparam logic [REQ_IDX_W-1:0] IDX_LAST = REQ_IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [REQ_IDX_W-1:0]   idx_q, idx_d;
  logic [REQ_IDX_W-1:0]   ptr_q, ptr_d;
  logic                   pick_vld;
  logic [REQ_IDX_W-1:0]   pick_idx;
  logic [REQ_IDX_W-1:0]   owner_inc;
  logic                   cnt_set;
  logic                   cnt_add;
  logic                   cnt_end;
  logic [TIMEOUT_W-1:0]   cnt_val;
  logic                   owner_done;

  // Scan from ptr upward, wrapping, and take the first active request.
  always_comb begin
    int                   c;
    logic [REQ_IDX_W-1:0] cidx;
    pick_vld = 1'b0;
    pick_idx = '0;
    c        = 0;
    cidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cidx = REQ_IDX_W'(c);
      if (!pick_vld && req_i[cidx]) begin
        pick_vld = 1'b1;
        pick_idx = cidx;
      end
    end
  end

  assign owner_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign owner_done = release_i || !req_i[idx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_set = 1'b0;
    cnt_add = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (en_i && pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = ONE_HOT0 << pick_idx;
          idx_d   = pick_idx;
          cnt_set = 1'b1;
        end
      end
      ST_GRANT: begin
        cnt_add = 1'b1;
        // Release takes priority over a watchdog expiry in the same cycle.
        if (owner_done) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = owner_inc;
        end else if (cnt_end) begin
          state_d = ST_EXPIRE;
          gnt_d   = '0;
          ptr_d   = owner_inc;
        end
      end
      ST_EXPIRE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  counter2 #(
    .CNT_SIZE       (TIMEOUT),
    .CNT_SIZE_WIDTH (TIMEOUT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (~rst),
    .set_i     (cnt_set),
    .set_val_i ('0),
    .add_i     (cnt_add),
    .cnt_o     (cnt_val),
    .end_o     (cnt_end)
  );

  assign gnt_o      = gnt_q;
  assign gnt_idx_o  = idx_q;
  assign busy_o     = (state_q == ST_GRANT);
  assign timeout_o  = (state_q == ST_EXPIRE);
  assign hold_cnt_o = busy_o ? cnt_val : '0;

endmodule

// File: tb/tb_rr_timeout_arb.sv
// Directed scoreboard bench for rr_timeout_arb with NUM_REQ=4, TIMEOUT=8.
module tb_rr_timeout_arb;

  logic       clk;
  logic       rst;
  logic       en_i;
  logic [3:0] req_i;
  logic       release_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;
  logic       busy_o;
  logic       timeout_o;
  logic [3:0] hold_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       to;
    logic [3:0] hold;
  } exp_t;

  exp_t sb[$];

  rr_timeout_arb #(
    .NUM_REQ   (4),
    .REQ_IDX_W (2),
    .TIMEOUT   (8),
    .TIMEOUT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .req_i      (req_i),
    .release_i  (release_i),
    .gnt_o      (gnt_o),
    .gnt_idx_o  (gnt_idx_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .hold_cnt_o (hold_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then compare.
  task automatic step(input string nm, input logic en, input logic [3:0] req, input logic rel,
                      input logic [3:0] eg, input logic [1:0] ei, input logic eb,
                      input logic et, input logic [3:0] eh);
    exp_t e;
    en_i      = en;
    req_i     = req;
    release_i = rel;
    e.gnt = eg; e.idx = ei; e.busy = eb; e.to = et; e.hold = eh;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, ".gnt"},  32'(gnt_o),      32'(e.gnt));
    if (e.busy) chk({nm, ".idx"}, 32'(gnt_idx_o), 32'(e.idx));
    chk({nm, ".busy"}, 32'(busy_o),     32'(e.busy));
    chk({nm, ".to"},   32'(timeout_o),  32'(e.to));
    chk({nm, ".hold"}, 32'(hold_cnt_o), 32'(e.hold));
    chk({nm, ".onehot"}, 32'($countones(gnt_o) <= 1), 32'd1);
  endtask

  initial begin
    rst = 1'b0; en_i = 1'b0; req_i = '0; release_i = 1'b0;
    #2;
    chk("rst.gnt",  32'(gnt_o), 32'd0);
    chk("rst.idx",  32'(gnt_idx_o), 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.to",   32'(timeout_o), 32'd0);
    chk("rst.hold", 32'(hold_cnt_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // First grant from ptr=0, then rotation after release.
    step("g1",    1, 4'b0110, 0, 4'b0010, 2'd1, 1, 0, 4'd0);
    step("rel1",  1, 4'b0110, 1, 4'b0000, 2'd1, 0, 0, 4'd0);
    step("g2",    1, 4'b0110, 0, 4'b0100, 2'd2, 1, 0, 4'd0);

    // Owner 2 holds until the watchdog fires.
    for (int k = 1; k <= 7; k++)
      step("hold2", 1, 4'b0110, 0, 4'b0100, 2'd2, 1, 0, 4'(k));
    step("expire", 1, 4'b0110, 0, 4'b0000, 2'd2, 0, 1, 4'd0);
    step("postex", 1, 4'b0110, 0, 4'b0000, 2'd2, 0, 0, 4'd0);
    step("g3",     1, 4'b0110, 0, 4'b0010, 2'd1, 1, 0, 4'd0);

    // Release in the final hold cycle beats the timeout; en_i low mid-grant is ignored.
    for (int k = 1; k <= 7; k++)
      step("hold1", (k >= 3 && k <= 5) ? 1'b0 : 1'b1, 4'b0110, 0, 4'b0010, 2'd1, 1, 0, 4'(k));
    step("rel_last", 1, 4'b0110, 1, 4'b0000, 2'd1, 0, 0, 4'd0);
    step("idle_chk", 0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, 4'd0);

    // ptr wrap from owner 3 to requester 0.
    step("g_own3", 1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 4'd0);
    step("rel3",   1, 4'b1001, 1, 4'b0000, 2'd3, 0, 0, 4'd0);
    step("wrap0",  1, 4'b1001, 0, 4'b0001, 2'd0, 1, 0, 4'd0);
    // Owner dropping its request also releases.
    step("drop0",  1, 4'b1000, 0, 4'b0000, 2'd0, 0, 0, 4'd0);
    step("en_off", 0, 4'b1000, 0, 4'b0000, 2'd0, 0, 0, 4'd0);
    step("no_req", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 4'd0);

    // Asynchronous reset in the middle of a grant.
    step("g_pre",  1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 4'd0);
    step("h_pre",  1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 4'd1);
    rst = 1'b0;
    #2;
    chk("arst.gnt",  32'(gnt_o), 32'd0);
    chk("arst.idx",  32'(gnt_idx_o), 32'd0);
    chk("arst.busy", 32'(busy_o), 32'd0);
    chk("arst.to",   32'(timeout_o), 32'd0);
    chk("arst.hold", 32'(hold_cnt_o), 32'd0);
    #1;
    rst = 1'b1;
    step("g_post", 1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 4'd0);
    step("h_post", 1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 4'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
